imm_extend_pipe: RTL and testbench

//   Parametrised, registered immediate extender for the decode stage. Accepts a raw IN_W-bit

---
 rtl/imm_extend_pipe_pkg.sv | 13 +
 rtl/imm_extend_pipe_if.sv | 47 ++++
 rtl/imm_extend_pipe_core.sv | 29 ++
 rtl/imm_extend_pipe.sv | 101 ++++++++++
 tb/tb_imm_extend_pipe.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared types for the immediate extender: extension mode encoding.
package imm_ext_pkg;

   localparam int EXT_MODE_W = 2;

   typedef enum logic [EXT_MODE_W-1:0] {
      EXT_ZERO     = 2'd0,
      EXT_SIGN     = 2'd1,
      EXT_SIGN_SHL = 2'd2,
      EXT_UPPER    = 2'd3
   } ext_mode_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus for imm_extend_pipe. Upstream push side (in_*) and
// downstream pop side (out_*). Tag sideband exists only with IMM_EXT_TAG_EN.
interface imm_extend_pipe_if
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 19,
   parameter int OUT_W = 32,
   parameter int TAG_W = 4
);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   ext_mode_t        in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
`ifdef IMM_EXT_TAG_EN
   logic [TAG_W-1:0] in_tag;
   logic [TAG_W-1:0] out_tag;
`endif

   if (TAG_W < 1) begin : g_tag_w_check
      $error("imm_extend_pipe_if: TAG_W must be >= 1");
   end

   // Drives the pipe: upstream producer and downstream consumer side.
   modport master (
      output in_valid, in_imm, in_mode, out_ready,
`ifdef IMM_EXT_TAG_EN
      output in_tag,
      input  out_tag,
`endif
      input  in_ready, out_valid, out_data
   );

   // The pipe itself.
   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
`ifdef IMM_EXT_TAG_EN
      input  in_tag,
      output out_tag,
`endif
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate extender: (imm, mode) -> OUT_W operand.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 19,
   parameter int OUT_W = 32,
   parameter int SHL   = 2
) (
   input  logic [IN_W-1:0]  imm,
   input  ext_mode_t        mode,
   output logic [OUT_W-1:0] ext
);

   logic [OUT_W-1:0] sext;

   // Select extension form; sign-extended value is shared by two modes.
   always_comb begin
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      ext  = '0;
      case (mode)
         EXT_ZERO:     ext = {{(OUT_W-IN_W){1'b0}}, imm};
         EXT_SIGN:     ext = sext;
         EXT_SIGN_SHL: ext = sext << SHL;
         EXT_UPPER:    ext = {imm, {(OUT_W-IN_W){1'b0}}};
         default:      ext = '0;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a 2-entry skid buffer.
// Optional macro IMM_EXT_TAG_EN adds a tag stored alongside each entry.
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 19,
   parameter int OUT_W = 32,
   parameter int SHL   = 2,
   parameter int TAG_W = 4
) (
   input logic               clk,
   input logic               rst,
   imm_extend_pipe_if.slave  bus
);

   if (IN_W < 1 || IN_W >= OUT_W) begin : g_w_check
      $error("imm_extend_pipe: need 1 <= IN_W < OUT_W");
   end
   if (IN_W + SHL > OUT_W) begin : g_shl_check
      $error("imm_extend_pipe: need IN_W+SHL <= OUT_W");
   end
   if (TAG_W < 1) begin : g_tag_check
      $error("imm_extend_pipe: TAG_W must be >= 1");
   end

   logic [OUT_W-1:0] ext;
   logic [1:0]       count, count_nxt;
   logic [OUT_W-1:0] data0, data1;   // data0 is the head entry
   logic             push, pop;
   logic             ld0_new, ld0_shift, ld1_new;

   imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHL(SHL)) u_core (
      .imm  (bus.in_imm),
      .mode (bus.in_mode),
      .ext  (ext)
   );

   assign bus.in_ready  = (count != 2'd2);
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_data  = data0;
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   // Entry load enables and next occupancy from push/pop at the current count.
   always_comb begin
      ld0_new   = 1'b0;
      ld0_shift = 1'b0;
      ld1_new   = 1'b0;
      count_nxt = count;
      case (count)
         2'd0: begin
            ld0_new = push;
            if (push) count_nxt = 2'd1;
         end
         2'd1: begin
            // push+pop at one entry replaces the head in place
            ld0_new = push & pop;
            ld1_new = push & ~pop;
            if (push & ~pop)      count_nxt = 2'd2;
            else if (pop & ~push) count_nxt = 2'd0;
         end
         default: begin
            ld0_shift = pop;
            if (pop) count_nxt = 2'd1;
         end
      endcase
   end

   // Occupancy and data storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         data0 <= '0;
         data1 <= '0;
      end else begin
         count <= count_nxt;
         if (ld0_new)        data0 <= ext;
         else if (ld0_shift) data0 <= data1;
         if (ld1_new)        data1 <= ext;
      end
   end

`ifdef IMM_EXT_TAG_EN
   logic [TAG_W-1:0] tag0, tag1;

   assign bus.out_tag = tag0;

   // Tag storage mirrors the data entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag0 <= '0;
         tag1 <= '0;
      end else begin
         if (ld0_new)        tag0 <= bus.in_tag;
         else if (ld0_shift) tag0 <= tag1;
         if (ld1_new)        tag1 <= bus.in_tag;
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (IN_W=19, OUT_W=32, SHL=2).
module tb_imm_extend_pipe;
   import imm_ext_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   imm_extend_pipe_if #(.IN_W(19), .OUT_W(32), .TAG_W(4)) bus ();

   imm_extend_pipe #(.IN_W(19), .OUT_W(32), .SHL(2), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [18:0] imm, input ext_mode_t m);
      bus.in_valid = v;
      bus.in_imm   = imm;
      bus.in_mode  = m;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      drive(1'b0, '0, EXT_ZERO);
      bus.out_ready = 1'b1;
`ifdef IMM_EXT_TAG_EN
      bus.in_tag = '0;
`endif
      #12;
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data",  bus.out_data,           32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Modes, one cycle after acceptance
      drive(1'b1, 19'h40000, EXT_SIGN); step(); drive(1'b0, '0, EXT_ZERO);
      chk("sign_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("sign_data",  bus.out_data, 32'hFFFC0000);
      step();
      drive(1'b1, 19'h40000, EXT_ZERO); step(); drive(1'b0, '0, EXT_ZERO);
      chk("zero_data", bus.out_data, 32'h00040000);
      step();
      drive(1'b1, 19'h7FFFF, EXT_SIGN_SHL); step(); drive(1'b0, '0, EXT_ZERO);
      chk("sshl_data", bus.out_data, 32'hFFFFFFFC);
      step();
      drive(1'b1, 19'h00001, EXT_UPPER); step(); drive(1'b0, '0, EXT_ZERO);
      chk("upper_data", bus.out_data, 32'h00002000);
      step();
      chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);

      // Streaming: 8 back-to-back, one output per cycle, in order
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 19'(i + 16), EXT_ZERO);
         step();
         chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("stream_data",  bus.out_data, 32'(i + 16));
         chk("stream_rdy",   {31'd0, bus.in_ready}, 32'd1);
      end
      drive(1'b0, '0, EXT_ZERO);
      step();
      chk("stream_drain", {31'd0, bus.out_valid}, 32'd0);

      // Backpressure: A, B accepted, C held
      bus.out_ready = 1'b0;
      drive(1'b1, 19'h0000A, EXT_ZERO); step();
      chk("bp_rdy_a", {31'd0, bus.in_ready}, 32'd1);
      drive(1'b1, 19'h0000B, EXT_ZERO); step();
      chk("bp_rdy_b", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_head",  bus.out_data, 32'h0000000A);
      drive(1'b1, 19'h0000C, EXT_ZERO);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("bp_stall_data", bus.out_data, 32'h0000000A);
         chk("bp_stall_rdy",  {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_out_b",   bus.out_data, 32'h0000000B);
      chk("bp_rdy_one", {31'd0, bus.in_ready}, 32'd1);
      step();
      drive(1'b0, '0, EXT_ZERO);
      chk("bp_out_c",   bus.out_data, 32'h0000000C);
      chk("bp_valid_c", {31'd0, bus.out_valid}, 32'd1);
      step();
      chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

      // Push+pop at count 1
      drive(1'b1, 19'h00111, EXT_ZERO); step();
      drive(1'b1, 19'h00222, EXT_ZERO); step();
      chk("pp_y",     bus.out_data, 32'h00000222);
      chk("pp_rdy_y", {31'd0, bus.in_ready}, 32'd1);
      drive(1'b1, 19'h00333, EXT_ZERO); step();
      chk("pp_z",     bus.out_data, 32'h00000333);
      chk("pp_rdy_z", {31'd0, bus.in_ready}, 32'd1);
      drive(1'b0, '0, EXT_ZERO); step();
      chk("pp_empty", {31'd0, bus.out_valid}, 32'd0);

      // Reset mid-op with two entries held
      bus.out_ready = 1'b0;
      drive(1'b1, 19'h00055, EXT_ZERO); step();
      drive(1'b1, 19'h00066, EXT_ZERO); step();
      drive(1'b0, '0, EXT_ZERO);
      chk("rm_full", {31'd0, bus.in_ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rm_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rm_data",  bus.out_data, 32'd0);
      chk("rm_rdy",   {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("rm_stale1", {31'd0, bus.out_valid}, 32'd0);
      step();
      chk("rm_stale2", {31'd0, bus.out_valid}, 32'd0);

`ifdef IMM_EXT_TAG_EN
      // Tags travel with their data under backpressure
      bus.out_ready = 1'b0;
      drive(1'b1, 19'h00011, EXT_ZERO); bus.in_tag = 4'h3; step();
      drive(1'b1, 19'h00022, EXT_ZERO); bus.in_tag = 4'hA; step();
      drive(1'b0, '0, EXT_ZERO); bus.in_tag = 4'h0;
      chk("tag_d0", bus.out_data, 32'h00000011);
      chk("tag_t0", {28'd0, bus.out_tag}, 32'h3);
      bus.out_ready = 1'b1;
      step();
      chk("tag_d1", bus.out_data, 32'h00000022);
      chk("tag_t1", {28'd0, bus.out_tag}, 32'hA);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
